alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that time-multiplexes one external 1-bit ALU slice over WIDTH-bit operands, LSB first. It latches operands and opcode on a Start handshake, steps the slice one bit per clock, and propagates carry internally for arithmetic ops. It reports Busy/Done and the WIDTH-bit Result with CarryOut. It sits between the register/switch front end and the 1-bit ALU slice.

---
 rtl/alu_serial_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial sequencer that drives one external 1-bit ALU slice over
//   WIDTH-bit operands, LSB first, and assembles the WIDTH-bit result.
//   Carry for the two arithmetic ops is kept in a local flop.
//
// Ports
//   Clk        system clock, rising edge
//   Rst_n      synchronous active-low reset
//   Start      operation request, accepted only when idle
//   Select     opcode select, latched on accept
//   Mode       0 = logic, 1 = arithmetic, latched on accept
//   OpA, OpB   WIDTH-bit operands, latched on accept
//   AluSelect  latched Select, to the slice
//   AluMode    latched Mode, to the slice
//   AluA/AluB  current operand bits, to the slice
//   AluOut     slice result bit (combinational from AluA/AluB)
//   Busy       operation in progress
//   Done       one-cycle completion pulse
//   Result     final result, held until the next completion
//   CarryOut   final carry, held with Result
//
// state  | meaning
// S_IDLE | waiting for Start; Result/CarryOut hold the last completion
// S_RUN  | one operand bit captured per clock, LSB first

module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Select,
  input  logic             Mode,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [1:0]       AluSelect,
  output logic             AluMode,
  output logic             AluA,
  output logic             AluB,
  input  logic             AluOut,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic             co_q, co_d;

  logic             arith;
  logic             a_eff;
  logic             bit_val;
  logic             c_nxt;

  always_comb begin
    arith   = 1'b0;
    a_eff   = 1'b0;
    bit_val = 1'b0;
    c_nxt   = 1'b0;

    // Only Mode=1 with Select=1x carries; Select[0] selects ~A+B.
    arith   = mode_q & sel_q[1];
    a_eff   = a_sh_q[0] ^ sel_q[0];
    bit_val = arith ? (AluOut ^ c_q) : AluOut;
    c_nxt   = arith ? ((a_eff & b_sh_q[0]) | (c_q & (a_eff ^ b_sh_q[0]))) : 1'b0;

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    c_d      = c_q;
    done_d   = 1'b0;
    co_d     = co_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_sh_d   = OpA;
          b_sh_d   = OpB;
          sel_d    = Select;
          mode_d   = Mode;
          c_d      = 1'b0;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {bit_val, res_sh_q[WIDTH-1:1]};
        c_d      = c_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the assembled word, which includes this bit.
          result_d = {bit_val, res_sh_q[WIDTH-1:1]};
          co_d     = c_nxt;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      done_q   <= done_d;
      co_q     <= co_d;
    end
  end

  assign AluSelect = sel_q;
  assign AluMode   = mode_q;
  assign AluA      = a_sh_q[0];
  assign AluB      = b_sh_q[0];
  assign Busy      = (state_q == S_RUN);
  assign Done      = done_q;
  assign Result    = result_q;
  assign CarryOut  = co_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Testbench for alu_serial_ctrl. Models the external 1-bit slice and
// compares each completed operation against a word-level reference.
//   Slice, logic mode:      00 A&B, 01 ~A, 10 A|B, 11 ~(A^B)
//   Slice, arithmetic mode: 00 A,   01 B,  10 A^B, 11 ~A^B
module tb_alu_serial_ctrl;
  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Start;
  logic [1:0]       Select;
  logic             Mode;
  logic [WIDTH-1:0] OpA, OpB;
  logic [1:0]       AluSelect;
  logic             AluMode, AluA, AluB, AluOut;
  logic             Busy, Done, CarryOut;
  logic [WIDTH-1:0] Result;

  int errs = 0;
  int checks = 0;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Select(Select), .Mode(Mode),
    .OpA(OpA), .OpB(OpB), .AluSelect(AluSelect), .AluMode(AluMode),
    .AluA(AluA), .AluB(AluB), .AluOut(AluOut), .Busy(Busy), .Done(Done),
    .Result(Result), .CarryOut(CarryOut)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    AluOut = 1'b0;
    if (AluMode) begin
      case (AluSelect)
        2'b00:   AluOut = AluA;
        2'b01:   AluOut = AluB;
        2'b10:   AluOut = AluA ^ AluB;
        default: AluOut = ~AluA ^ AluB;
      endcase
    end else begin
      case (AluSelect)
        2'b00:   AluOut = AluA & AluB;
        2'b01:   AluOut = ~AluA;
        2'b10:   AluOut = AluA | AluB;
        default: AluOut = ~(AluA ^ AluB);
      endcase
    end
  end

  // Word-level reference: whole-operand arithmetic, no bit stepping.
  function automatic void ref_op(input logic m, input logic [1:0] s,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output logic [WIDTH-1:0] r, output logic co);
    logic [WIDTH:0] sum;
    sum = '0;
    co  = 1'b0;
    r   = '0;
    if (m) begin
      case (s)
        2'b00: r = a;
        2'b01: r = b;
        2'b10: begin sum = {1'b0, a} + {1'b0, b};  r = sum[WIDTH-1:0]; co = sum[WIDTH]; end
        default: begin sum = {1'b0, ~a} + {1'b0, b}; r = sum[WIDTH-1:0]; co = sum[WIDTH]; end
      endcase
    end else begin
      case (s)
        2'b00: r = a & b;
        2'b01: r = ~a;
        2'b10: r = a | b;
        default: r = ~(a ^ b);
      endcase
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    OpA    = WIDTH'($urandom);
    OpB    = WIDTH'($urandom);
    Select = 2'($urandom);
    Mode   = 1'($urandom);
  endtask

  // Waits (bounded) for Done; while waiting, Busy must stay high and
  // Result must not move.
  task automatic wait_done(input logic [WIDTH-1:0] prev_res, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    repeat (WIDTH + 3) begin
      if (!seen) begin
        @(posedge Clk);
        #1;
        lat++;
        if (Done) seen = 1'b1;
        else begin
          check("busy_during_run", 32'(Busy), 32'd1);
          check("result_stable", 32'(Result), 32'(prev_res));
        end
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [1:0] s,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] er, input logic eco);
    logic [WIDTH-1:0] prev;
    int lat;
    bit seen;
    prev   = Result;
    Mode   = m;
    Select = s;
    OpA    = a;
    OpB    = b;
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    scramble_inputs();
    check({tag, "_busy_after_accept"}, 32'(Busy), 32'd1);
    check({tag, "_alu_mode"}, 32'({AluMode, AluSelect}), 32'({m, s}));
    wait_done(prev, lat, seen);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
      check({tag, "_result"}, 32'(Result), 32'(er));
      check({tag, "_carry"}, 32'(CarryOut), 32'(eco));
      check({tag, "_busy_in_done"}, 32'(Busy), 32'd0);
      @(posedge Clk);
      #1;
      check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
      check({tag, "_result_held"}, 32'(Result), 32'(er));
    end
  endtask

  typedef struct {
    logic             mode;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             co;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [WIDTH-1:0] er;
    logic eco;
    logic m;
    logic [1:0] s;
    logic [WIDTH-1:0] a, b;
    int lat;
    bit seen;
    int done_cnt;

    vecs[0]  = '{1'b1, 2'b10, 8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 2'b11, 8'h0F, 8'h20, 8'h10, 1'b1};
    vecs[3]  = '{1'b0, 2'b11, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 8'h33, 8'hC4, 8'h33, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 8'h33, 8'hC4, 8'hC4, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[10] = '{1'b1, 2'b10, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 1'b0};

    Rst_n  = 1'b0;
    Start  = 1'b0;
    Mode   = 1'b0;
    Select = 2'b00;
    OpA    = '0;
    OpB    = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_carry", 32'(CarryOut), 32'd0);
    check("rst_alu_ab", 32'({AluA, AluB}), 32'd0);
    check("rst_alu_sel_mode", 32'({AluMode, AluSelect}), 32'd0);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check("idle_no_start", 32'(Busy), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].sel, vecs[i].a,
             vecs[i].b, vecs[i].res, vecs[i].co);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      s = 2'($urandom);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      ref_op(m, s, a, b, er, eco);
      run_op($sformatf("rnd%0d", i), m, s, a, b, er, eco);
    end

    // Start held through RUN with other operands, then back-to-back accept.
    Mode = 1'b1; Select = 2'b10; OpA = 8'h5A; OpB = 8'h3C;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Mode = 1'b0; Select = 2'b10; OpA = 8'h12; OpB = 8'h40;
    check("hold_busy", 32'(Busy), 32'd1);
    wait_done(Result, lat, seen);
    if (seen) begin
      check("hold_latency", 32'(lat), 32'(WIDTH));
      check("hold_result", 32'(Result), 32'h96);
      check("hold_carry", 32'(CarryOut), 32'd0);
    end
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("b2b_accept_busy", 32'(Busy), 32'd1);
    check("b2b_done_low", 32'(Done), 32'd0);
    wait_done(8'h96, lat, seen);
    if (seen) begin
      check("b2b_latency", 32'(lat), 32'(WIDTH));
      check("b2b_result", 32'(Result), 32'h52);
      check("b2b_carry", 32'(CarryOut), 32'd0);
    end
    @(posedge Clk);
    #1;

    // Reset in the middle of an add: discarded, outputs cleared, no Done.
    Mode = 1'b1; Select = 2'b10; OpA = 8'h33; OpB = 8'h44;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_result", 32'(Result), 32'd0);
    check("midrst_carry", 32'(CarryOut), 32'd0);
    done_cnt = 0;
    repeat (WIDTH + 2) begin
      @(posedge Clk);
      #1;
      if (Done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_op("post_rst", 1'b1, 2'b10, 8'hC8, 8'h64, 8'h2C, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
